// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with write-through bypass, load-use hazard detection, ID/EX register.
// Latency 1 cycle to ID/EX; stall_d freezes upstream on load-use, hold_e freezes ID/EX, flush_e squashes it.
module decode_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int CTRL_W   = 8,
  parameter int LOAD_BIT = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc4_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              valid_d,
  input  logic              flush_e,
  input  logic              hold_e,
  input  logic              reg_write_w,
  input  logic [AW-1:0]     rd_w,
  input  logic [XLEN-1:0]   result_w,
  output logic              stall_d,
  output logic              valid_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc4_e,
  output logic [AW-1:0]     rd_e,
  output logic [AW-1:0]     rs1_e,
  output logic [AW-1:0]     rs2_e
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc4;
    logic [AW-1:0]     rd;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
  } idex_t;

  logic [AW-1:0]   rs1_d;
  logic [AW-1:0]   rs2_d;
  logic [AW-1:0]   rd_d;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;
  logic [XLEN-1:0] rf [NREGS];
  logic            wr_en;
  logic            hz;
  idex_t           idex_q;
  idex_t           idex_nxt;
  logic            unused_instr_bits;

  assign rs1_d = instr_d[15 +: AW];
  assign rs2_d = instr_d[20 +: AW];
  assign rd_d  = instr_d[7 +: AW];
  assign unused_instr_bits = ^instr_d;

  assign wr_en = reg_write_w && (rd_w != '0);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_en) begin
      rf[rd_w] <= result_w;
    end
  end

  always_comb begin
    rd1_d = rf[rs1_d];
    if (rs1_d == '0) begin
      rd1_d = '0;
    end else if (wr_en && (rd_w == rs1_d)) begin
      rd1_d = result_w;
    end
  end

  always_comb begin
    rd2_d = rf[rs2_d];
    if (rs2_d == '0) begin
      rd2_d = '0;
    end else if (wr_en && (rd_w == rs2_d)) begin
      rd2_d = result_w;
    end
  end

  // Evaluated against whatever ID/EX currently holds, including held contents.
  assign hz = idex_q.valid && idex_q.ctrl[LOAD_BIT] && (idex_q.rd != '0) && valid_d &&
              ((idex_q.rd == rs1_d) || (idex_q.rd == rs2_d));

  assign stall_d = hz && !flush_e;

  always_comb begin
    idex_nxt = idex_q;
    if (flush_e) begin
      idex_nxt = '0;
    end else if (hold_e) begin
      idex_nxt = idex_q;
    end else if (hz) begin
      idex_nxt = '0;
    end else begin
      idex_nxt.valid = valid_d;
      idex_nxt.ctrl  = ctrl_d;
      idex_nxt.rd1   = rd1_d;
      idex_nxt.rd2   = rd2_d;
      idex_nxt.imm   = imm_d;
      idex_nxt.pc    = pc_d;
      idex_nxt.pc4   = pc4_d;
      idex_nxt.rd    = rd_d;
      idex_nxt.rs1   = rs1_d;
      idex_nxt.rs2   = rs2_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_nxt;
    end
  end

  assign valid_e = idex_q.valid;
  assign ctrl_e  = idex_q.ctrl;
  assign rd1_e   = idex_q.rd1;
  assign rd2_e   = idex_q.rd2;
  assign imm_e   = idex_q.imm;
  assign pc_e    = idex_q.pc;
  assign pc4_e   = idex_q.pc4;
  assign rd_e    = idex_q.rd;
  assign rs1_e   = idex_q.rs1;
  assign rs2_e   = idex_q.rs2;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomised and directed bench for decode_stage_pipe against an architectural model.
module tb_decode_stage_pipe;
  localparam int XLEN = 32, NREGS = 32, CTRL_W = 8, LOAD_BIT = 1, AW = 5;

  logic              clk, rst;
  logic [31:0]       instr_d;
  logic [XLEN-1:0]   pc_d, pc4_d, imm_d, result_w;
  logic [CTRL_W-1:0] ctrl_d;
  logic              valid_d, flush_e, hold_e, reg_write_w;
  logic [AW-1:0]     rd_w;
  logic              stall_d, valid_e;
  logic [CTRL_W-1:0] ctrl_e;
  logic [XLEN-1:0]   rd1_e, rd2_e, imm_e, pc_e, pc4_e;
  logic [AW-1:0]     rd_e, rs1_e, rs2_e;

  decode_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS), .CTRL_W(CTRL_W), .LOAD_BIT(LOAD_BIT)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc4_d(pc4_d), .imm_d(imm_d),
    .ctrl_d(ctrl_d), .valid_d(valid_d), .flush_e(flush_e), .hold_e(hold_e),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w), .stall_d(stall_d),
    .valid_e(valid_e), .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .pc_e(pc_e), .pc4_e(pc4_e), .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model: register array plus the instruction currently in EX.
  logic [XLEN-1:0]   m_rf [NREGS];
  logic              m_valid = 1'b0;
  logic [CTRL_W-1:0] m_ctrl = '0;
  logic [XLEN-1:0]   m_rd1 = '0, m_rd2 = '0, m_imm = '0, m_pc = '0, m_pc4 = '0;
  logic [AW-1:0]     m_rd = '0, m_rs1 = '0, m_rs2 = '0;
  logic [XLEN-1:0]   m_r1, m_r2;
  logic              m_h;

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (reg_write_w && rd_w == a) return result_w;
    return m_rf[a];
  endfunction

  function automatic logic m_hz();
    logic [AW-1:0] s1, s2;
    s1 = instr_d[15 +: AW];
    s2 = instr_d[20 +: AW];
    return m_valid && m_ctrl[LOAD_BIT] && (m_rd != 0) && valid_d && (m_rd == s1 || m_rd == s2);
  endfunction

  task automatic m_bubble();
    m_valid = 1'b0; m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
    m_pc = '0; m_pc4 = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_bubble();
      for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
    end else begin
      m_r1 = m_read(instr_d[15 +: AW]);
      m_r2 = m_read(instr_d[20 +: AW]);
      m_h  = m_hz();
      if (flush_e) m_bubble();
      else if (hold_e) begin end
      else if (m_h) m_bubble();
      else begin
        m_valid = valid_d; m_ctrl = ctrl_d; m_rd1 = m_r1; m_rd2 = m_r2; m_imm = imm_d;
        m_pc = pc_d; m_pc4 = pc4_d; m_rd = instr_d[7 +: AW];
        m_rs1 = instr_d[15 +: AW]; m_rs2 = instr_d[20 +: AW];
      end
      if (reg_write_w && rd_w != 0) m_rf[rd_w] = result_w;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle, mid-period: all outputs against the model.
  always @(negedge clk) begin
    check("valid_e", valid_e, m_valid);
    check("ctrl_e", ctrl_e, m_ctrl);
    check("rd1_e", rd1_e, m_rd1);
    check("rd2_e", rd2_e, m_rd2);
    check("imm_e", imm_e, m_imm);
    check("pc_e", pc_e, m_pc);
    check("pc4_e", pc4_e, m_pc4);
    check("rd_e", rd_e, m_rd);
    check("rs1_e", rs1_e, m_rs1);
    check("rs2_e", rs2_e, m_rs2);
    check("stall_d", stall_d, rst ? (m_hz() && !flush_e) : 1'b0);
  end

  function automatic logic [31:0] mk_instr(input int rd, input int rs1, input int rs2);
    logic [31:0] i;
    i = 32'h0000_0033;
    i[11:7]  = rd[4:0];
    i[19:15] = rs1[4:0];
    i[24:20] = rs2[4:0];
    return i;
  endfunction

  task automatic set_dec(input logic [31:0] ins, input logic [CTRL_W-1:0] c, input logic v,
                         input logic [XLEN-1:0] pc);
    instr_d = ins; ctrl_d = c; valid_d = v; pc_d = pc; pc4_d = pc + 4; imm_d = ~pc;
  endtask

  task automatic set_wb(input logic we, input int r, input logic [XLEN-1:0] d);
    reg_write_w = we; rd_w = r[AW-1:0]; result_w = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ins;
    rst = 1'b0; flush_e = 1'b0; hold_e = 1'b0;
    set_dec(32'h0, 8'h0, 1'b0, 32'h0);
    set_wb(1'b0, 0, 32'h0);
    repeat (3) next_cycle();
    check("reset_valid", valid_e, 1'b0);
    check("reset_stall", stall_d, 1'b0);
    rst = 1'b1;
    next_cycle();

    // Writeback then read through the register file.
    set_wb(1'b1, 5, 32'h1234);
    next_cycle();
    set_wb(1'b0, 0, 32'h0);
    set_dec(mk_instr(1, 5, 0), 8'h01, 1'b1, 32'h10);
    next_cycle();
    check("rf_read_rd1", rd1_e, 32'h1234);
    check("rf_read_valid", valid_e, 1'b1);

    // Same-cycle write-through bypass.
    set_wb(1'b1, 7, 32'hCAFE);
    set_dec(mk_instr(2, 0, 7), 8'h01, 1'b1, 32'h14);
    next_cycle();
    set_wb(1'b0, 0, 32'h0);
    check("bypass_rd2", rd2_e, 32'hCAFE);

    // Load-use: one bubble, then the consumer enters EX.
    set_dec(mk_instr(3, 0, 0), 8'h03, 1'b1, 32'h20);
    next_cycle();
    set_dec(mk_instr(4, 3, 0), 8'h01, 1'b1, 32'h40);
    #1 check("lu_stall_hi", stall_d, 1'b1);
    next_cycle();
    check("lu_bubble_valid", valid_e, 1'b0);
    check("lu_bubble_ctrl", ctrl_e, 8'h00);
    #1 check("lu_stall_lo", stall_d, 1'b0);
    next_cycle();
    check("lu_consumer_valid", valid_e, 1'b1);
    check("lu_consumer_rs1", rs1_e, 5'd3);
    check("lu_consumer_pc", pc_e, 32'h40);

    // Flush overrides a pending load-use stall.
    set_dec(mk_instr(3, 0, 0), 8'h03, 1'b1, 32'h50);
    next_cycle();
    set_dec(mk_instr(4, 3, 0), 8'h01, 1'b1, 32'h54);
    flush_e = 1'b1;
    #1 check("flush_stall", stall_d, 1'b0);
    next_cycle();
    flush_e = 1'b0;
    check("flush_valid", valid_e, 1'b0);
    check("flush_ctrl", ctrl_e, 8'h00);

    // Hold freezes ID/EX while writeback to x9 still lands.
    set_dec(mk_instr(2, 0, 0), 8'h05, 1'b1, 32'h100);
    next_cycle();
    hold_e = 1'b1;
    set_dec(mk_instr(6, 1, 1), 8'h01, 1'b1, 32'h200);
    set_wb(1'b1, 9, 32'h99);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      set_wb(1'b0, 0, 32'h0);
      check("hold_pc", pc_e, 32'h100);
      check("hold_ctrl", ctrl_e, 8'h05);
    end
    hold_e = 1'b0;
    set_dec(mk_instr(6, 9, 0), 8'h01, 1'b1, 32'h204);
    next_cycle();
    check("hold_x9_read", rd1_e, 32'h99);
    check("hold_release_pc", pc_e, 32'h204);

    // Asynchronous reset mid-stream clears EX and the register file.
    set_dec(mk_instr(8, 9, 5), 8'h07, 1'b1, 32'h300);
    next_cycle();
    rst = 1'b0;
    #1;
    check("arst_valid", valid_e, 1'b0);
    check("arst_ctrl", ctrl_e, 8'h00);
    check("arst_pc", pc_e, 32'h0);
    check("arst_stall", stall_d, 1'b0);
    next_cycle();
    rst = 1'b1;
    set_wb(1'b1, 0, 32'hFFFF);
    set_dec(mk_instr(1, 0, 0), 8'h01, 1'b1, 32'h400);
    next_cycle();
    set_wb(1'b0, 0, 32'h0);
    check("x0_reads_zero", rd1_e, 32'h0);
    set_dec(mk_instr(1, 5, 9), 8'h01, 1'b1, 32'h404);
    next_cycle();
    check("x5_cleared", rd1_e, 32'h0);
    check("x9_cleared", rd2_e, 32'h0);

    // Randomised traffic with small register indices to provoke hazards and bypasses.
    for (int n = 0; n < 2000; n++) begin
      ins = $urandom;
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      set_dec(ins, 8'($urandom), $urandom_range(0, 3) != 0, $urandom);
      flush_e = ($urandom_range(0, 9) == 0);
      hold_e  = ($urandom_range(0, 7) == 0);
      set_wb($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      rst = ($urandom_range(0, 299) != 0);
      next_cycle();
    end
    rst = 1'b1; flush_e = 1'b0; hold_e = 1'b0;
    set_wb(1'b0, 0, 32'h0);
    set_dec(32'h0, 8'h0, 1'b0, 32'h0);
    repeat (3) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

Interface
REQ-001 Parameter XLEN, default 32: data and PC width in bits.
REQ-002 Parameter NREGS, default 32: architectural register count (16 or 32); AW = clog2(NREGS).
REQ-003 Parameter CTRL_W, default 8: width of the control bundle.
REQ-004 Parameter LOAD_BIT, default 1: index of the "is load" flag inside the control bundle.
REQ-005 Port clk, in, 1: clock; all state updates on its rising edge.
REQ-006 Port rst, in, 1: reset, asynchronous, active-low.
REQ-007 Port instr_d, in, 32: decode-stage instruction.
REQ-008 Port pc_d / pc4_d, in, XLEN each: decode PC and PC+4.
REQ-009 Port imm_d, in, XLEN: extended immediate.
REQ-010 Port ctrl_d, in, CTRL_W: control bundle; bit 0 = RegWrite.
REQ-011 Port valid_d, in, 1: decode slot holds a real instruction.
REQ-012 Port flush_e, in, 1: squash the ID/EX contents (taken branch or jump).
REQ-013 Port hold_e, in, 1: freeze ID/EX (downstream stall).
REQ-014 Port reg_write_w, in, 1: writeback enable.
REQ-015 Port rd_w, in, AW: writeback destination register.
REQ-016 Port result_w, in, XLEN: writeback data.
REQ-017 Port stall_d, out, 1: freeze PC and IF/ID this cycle (combinational).
REQ-018 Port valid_e, out, 1: ID/EX holds a real instruction.
REQ-019 Port ctrl_e, out, CTRL_W: registered control bundle.
REQ-020 Port rd1_e / rd2_e / imm_e / pc_e / pc4_e, out, XLEN each: registered operands, immediate and PCs.
REQ-021 Port rd_e / rs1_e / rs2_e, out, AW each: registered register indices.

Function
REQ-022 Field extraction: rs1_d = instr_d[15+AW-1:15]; rs2_d = instr_d[20+AW-1:20]; rd_d = instr_d[7+AW-1:7].
REQ-023 Register file: NREGS x XLEN, two combinational read ports and one write port; writes on the rising edge when reg_write_w=1 and rd_w!=0.
REQ-024 Register 0 always reads 0; writes to it are discarded.
REQ-025 Write-through bypass: if reg_write_w=1, rd_w!=0 and rd_w equals the read address, that read port returns result_w in the same cycle.
REQ-026 Load-use hazard: hz = valid_e & ctrl_e[LOAD_BIT] & (rd_e!=0) & valid_d & (rd_e==rs1_d | rd_e==rs2_d).
REQ-027 stall_d = hz & ~flush_e.
REQ-028 ID/EX update priority, highest first: (1) flush_e -> bubble; (2) hold_e -> hold all fields; (3) hz -> bubble; (4) otherwise load the decode values; valid_e takes valid_d.
REQ-029 Bubble: valid_e=0 and ctrl_e=0; the data, index and PC fields are don't-care but shall load 0.
REQ-030 Latency: decode inputs appear on the ID/EX outputs 1 cycle later when no stall, hold or flush is active.
REQ-031 While hold_e=1, hz is evaluated against the held ID/EX contents; stall_d follows REQ-027.
REQ-032 Register file writes proceed regardless of stall_d, hold_e and flush_e.

Reset
REQ-033 While rst=0, all ID/EX outputs are 0 immediately (valid_e=0, ctrl_e=0) and every register-file entry is cleared to 0.
REQ-034 stall_d=0 during reset.
REQ-035 Reset asserted mid-operation discards the in-flight ID/EX contents; there is no partial state after release.
REQ-036 The first rising edge after rst rises performs a normal REQ-028 update.

Verification
REQ-037 Write x5=0x1234 via writeback, then decode add rs1=5 -> rd1_e=0x1234 with valid_e=1 one cycle later.
REQ-038 Same cycle reg_write_w=1, rd_w=7, result_w=0xCAFE while decoding rs2=7 -> rd2_e=0xCAFE next cycle (bypass).
REQ-039 Load with rd=3 in EX, decode rs1=3 -> stall_d=1 and bubble inserted; next cycle stall_d=0 and the consumer enters EX.
REQ-040 flush_e=1 together with hz=1 -> stall_d=0, valid_e=0, ctrl_e=0.
REQ-041 hold_e=1 for 3 cycles with a new decode instruction -> ID/EX unchanged; writeback to x9 still lands and reads back correctly.
REQ-042 Pulse rst low mid-stream -> all outputs 0 asynchronously; writes to x0 leave rd1 reading 0.
